// File: rtl/ss_entry_sched_if.sv
// Bundle of key-entry inputs, shared-decoder handshake and display outputs
// for the digit-entry scheduler.
interface ss_entry_sched_if;
    logic [3:0] key;
    logic       key_strobe;
    logic       bksp;
    logic       clr;
    logic [3:0] dec_in;
    logic       dec_en;
    logic [6:0] dec_seg;
    logic [7:0] ss0;
    logic [7:0] ss1;
    logic [7:0] ss2;
    logic [7:0] ss3;
    logic [7:0] ss4;
    logic [7:0] ss5;
    logic [7:0] ss6;
    logic [7:0] ss7;
    logic [2:0] sel;
    logic [3:0] count;
    logic       full;

    modport slave (
        input  key, key_strobe, bksp, clr, dec_seg,
        output dec_in, dec_en, ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7, sel, count, full
    );

    modport master (
        output key, key_strobe, bksp, clr, dec_seg,
        input  dec_in, dec_en, ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7, sel, count, full
    );
endinterface

// File: rtl/ss_entry_sched.sv
// Calculator-style 8-digit entry buffer with a scanned, shared seven-segment
// decoder whose output is latched per display.
module ss_entry_sched #(
    parameter int unsigned SCAN_HOLD = 1
) (
    input  logic            hz100,
    input  logic            reset,
    ss_entry_sched_if.slave bus
);
    logic [3:0] dig_q [8];
    logic [3:0] dig_d [8];
    logic [7:0] v_q;
    logic [7:0] v_d;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       key_q;
    logic       bksp_q;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic [7:0] tmr_q;
    logic [7:0] tmr_d;
    logic [7:0] ss_q [8];
    logic [7:0] ss_d [8];
    logic       press_s;
    logic       back_s;
    logic       slot_end_s;

    assign press_s    = bus.key_strobe & ~key_q;
    assign back_s     = bus.bksp & ~bksp_q;
    assign slot_end_s = (tmr_q == 8'(SCAN_HOLD - 1));

    // Entry buffer next state: clr beats backspace beats press, losers are dropped
    always_comb begin
        dig_d   = dig_q;
        v_d     = v_q;
        count_d = count_q;
        if (bus.clr) begin
            for (int i = 0; i < 8; i++) begin
                dig_d[i] = 4'd0;
            end
            v_d     = 8'd0;
            count_d = 4'd0;
        end else if (back_s) begin
            if (count_q != 4'd0) begin
                for (int i = 0; i < 7; i++) begin
                    dig_d[i] = dig_q[i+1];
                end
                dig_d[7] = 4'd0;
                v_d      = {1'b0, v_q[7:1]};
                count_d  = count_q - 4'd1;
            end else begin
                count_d = count_q;
            end
        end else if (press_s) begin
            if (count_q != 4'd8) begin
                for (int i = 7; i > 0; i--) begin
                    dig_d[i] = dig_q[i-1];
                end
                dig_d[0] = bus.key;
                v_d      = {v_q[6:0], 1'b1};
                count_d  = count_q + 4'd1;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Scan next state: capture decoder output on the last cycle of each slot
    always_comb begin
        ss_d = ss_q;
        if (slot_end_s) begin
            tmr_d        = 8'd0;
            sel_d        = sel_q + 3'd1;
            ss_d[sel_q]  = {1'b0, bus.dec_seg};
        end else begin
            tmr_d = tmr_q + 8'd1;
            sel_d = sel_q;
        end
    end

    // State registers
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= 4'd0;
                ss_q[i]  <= 8'd0;
            end
            v_q     <= 8'd0;
            count_q <= 4'd0;
            key_q   <= 1'b0;
            bksp_q  <= 1'b0;
            sel_q   <= 3'd0;
            tmr_q   <= 8'd0;
        end else begin
            dig_q   <= dig_d;
            ss_q    <= ss_d;
            v_q     <= v_d;
            count_q <= count_d;
            key_q   <= bus.key_strobe;
            bksp_q  <= bus.bksp;
            sel_q   <= sel_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.dec_in = dig_q[sel_q];
    assign bus.dec_en = v_q[sel_q];
    assign bus.ss0    = ss_q[0];
    assign bus.ss1    = ss_q[1];
    assign bus.ss2    = ss_q[2];
    assign bus.ss3    = ss_q[3];
    assign bus.ss4    = ss_q[4];
    assign bus.ss5    = ss_q[5];
    assign bus.ss6    = ss_q[6];
    assign bus.ss7    = ss_q[7];
    assign bus.sel    = sel_q;
    assign bus.count  = count_q;
    assign bus.full   = (count_q == 4'd8);
endmodule

// File: doc/ss_entry_sched.md
# ss_entry_sched

Digit-entry controller and display scheduler for the push-button / seven-segment datapath. It turns priority-encoded key events (4-bit value plus strobe from the key encoder) into an 8-digit calculator-style entry buffer. It time-shares a single combinational seven-segment decoder across all eight displays by scanning a select counter. Each decoded pattern is latched into that display's segment register, so every display holds its image between scans.

## Interface
Parameters:
- SCAN_HOLD, default 1: clock cycles spent on each display slot, range 1..255.

Ports:
- hz100  in  1  system clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key  in  4  encoded key value from the priority encoder.
- key_strobe  in  1  high while any encoded key is pressed.
- bksp  in  1  backspace button, level.
- clr  in  1  clear button, level.
- dec_in  out  4  digit currently presented to the shared decoder, equal to dig[sel].
- dec_en  out  1  decoder enable, equal to v[sel]. Low blanks the slot.
- dec_seg  in  7  decoder segment output. Combinational response to dec_in/dec_en in the same cycle.
- ss0 … ss7  out  8 each  latched segment patterns. Bit 7 (dp) is always 0.
- sel  out  3  current scan slot.
- count  out  4  number of valid digits, 0..8.
- full  out  1  high when count == 8 (combinational from count).

## Operation
- State:
  - dig[0..7], 4 bits each. dig[0] is the rightmost digit.
  - v[0..7] valid bits.
  - count.
  - key_q, bksp_q: previous-cycle samples used for edge detection.
  - sel, plus slot timer tmr of 8 bits.
  - ss0..ss7 latches.
- Events, evaluated every cycle:
  - press = key_strobe & ~key_q
  - back = bksp & ~bksp_q
  - clr is level-sensitive and acts every cycle it is high.
- Priority when events coincide, one action per cycle:
  - clr: all dig and v set to 0, count set to 0.
  - else back: if count > 0, dig[i] <= dig[i+1] and v[i] <= v[i+1] for i = 0..6; dig[7] and v[7] set to 0; count decrements. If count == 0, no change.
  - else press: if count < 8, dig[i] <= dig[i-1] and v[i] <= v[i-1] for i = 7..1; dig[0] <= key; v[0] <= 1; count increments. If count == 8, the press is dropped with no state change.
  - Any lower-priority event in the same cycle is discarded, not deferred.
- Holding a key or bksp produces exactly one event; there is no auto-repeat. A new event requires the input to be released for at least one cycle.
- key_q and bksp_q update every cycle, including cycles where clr is high. A key held while clr is released therefore does not generate a press.
- Scan:
  - tmr counts 0..SCAN_HOLD-1.
  - When tmr == SCAN_HOLD-1: ss[sel] <= {1'b0, dec_seg}; tmr set to 0; sel increments, wrapping 7→0.
  - Otherwise tmr increments.
- Slots with v = 0 capture dec_seg, which is 0 because the decoder is disabled, so unused digits blank.
- clr and back do not write ss latches directly. Displays reflect the buffer after at most 8·SCAN_HOLD cycles.

## Timing
- Reset asserted: all outputs and state are 0 immediately (asynchronous): ss0..ss7 = 0, sel = 0, count = 0, full = 0, dec_en = 0, dec_in = 0, key_q = bksp_q = 0.
- A key held across reset deassertion registers one press on the first clock edge after release.
- Buffer latency: an event sampled at edge N is visible on count, dig and v after edge N. The latency is one cycle from the input rising.
- Display latency: a buffer change becomes visible on ss[k] at the end of the next slot k. With SCAN_HOLD = 1 this is at most 8 cycles.
- Scan period is 8·SCAN_HOLD cycles. Slot order is 0,1,…,7,0,… with no gaps; reset restarts it at slot 0.
- dec_in and dec_en change only when sel changes or dig/v change. The ss capture uses the dec_seg value present during the last cycle of the slot.
- Reset asserted mid-slot or mid-event aborts it. No partial shift survives.

## Test plan
- Reset then press keys 3, 5, 9 with one-cycle gaps, SCAN_HOLD = 1 → count = 3; dig[2:0] = 3,5,9. Within 8 cycles ss0 = 7-segment '9', ss1 = '5', ss2 = '3', and ss3..ss7 = 0.
- Press nine distinct keys → count = 8 and full = 1 after the 8th press. The 9th press is dropped: dig unchanged and count stays 8.
- With count = 3 (digits 3,5,9), pulse bksp → count = 2, digits 3,5. ss0 shows '5' and ss2 blanks within one scan period. A further bksp held for 20 cycles decrements count exactly once.
- Same-cycle press and bksp rising, with count = 2 → bksp wins, count = 1, key discarded. clr held together with a press → count = 0, and releasing clr with the key still held produces no press.
- SCAN_HOLD = 4: sel dwells 4 cycles per slot and wraps 7→0 every 32 cycles. An ss latch updates only on the 4th cycle of its slot.
- Assert reset mid-scan with count = 5 → all ss outputs, sel and count are 0 immediately without a clock edge. The first edge after release with key_strobe high yields count = 1.
